// File: rtl/switch_pkg.sv
// Shared types for the switch datapath: flit layout, head-flit fields and the
// input-buffer routing states.
package switch_pkg;

    localparam int unsigned FLIT_W    = 32;
    localparam int unsigned DEST_W    = 5;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned PAYLOAD_W = 23;
    localparam int unsigned MAX_NODES = 32;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic [LEN_W-1:0]     len;
        logic [PAYLOAD_W-1:0] payload;
    } head_flit_t;

    typedef enum logic [1:0] {
        ROUTE = 2'd0,
        FWD   = 2'd1,
        DROP  = 2'd2
    } ibuf_state_t;

endpackage

// File: rtl/switch_flit_fifo.sv
// Flit storage for one ingress port: circular buffer with occupancy count,
// registered full flag and same-cycle push/pop acceptance when full.
module switch_flit_fifo
    import switch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   wen,
    input  flit_t                  wdata,
    input  logic                   deq,
    output flit_t                  rdata_c,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next_c,
    output logic                   full,
    output logic                   overflow_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    flit_t            mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_pop;
    logic             push_ok;

    // A pop frees the slot the simultaneous push needs, so full does not block it.
    assign do_pop       = deq && (count != '0);
    assign push_ok      = wen && (!full || do_pop);
    assign overflow_c   = wen && full && !do_pop;
    assign count_next_c = count + CNT_W'(push_ok) - CNT_W'(do_pop);
    assign rdata_c      = (count != '0) ? mem[rptr] : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            count <= count_next_c;
            full  <= (count_next_c == CNT_W'(DEPTH));
        end
    end

    // Storage array needs no reset; rdata is masked while empty.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/switch_input_buffer.sv
// Wormhole input buffer: routes each packet head through a programmable table,
// bids one-hot toward the chosen output and returns a credit per popped flit.
module switch_input_buffer
    import switch_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned NUM_OUTPORTS = 4,
    parameter int unsigned TOTAL_NODES  = 32
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            wen,
    input  flit_t                           wdata,
    input  logic                            pop,
    input  logic                            rt_wen,
    input  logic [DEST_W-1:0]               rt_addr,
    input  logic [$clog2(NUM_OUTPORTS)-1:0] rt_port,
    output logic [NUM_OUTPORTS-1:0]         bid,
    output flit_t                           rdata,
    output logic                            full,
    output logic                            credit_ret,
    output logic                            overflow_err,
    output logic                            route_err
);
    localparam int unsigned PORT_W = $clog2(NUM_OUTPORTS);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned REM_W  = LEN_W + 1;

    ibuf_state_t              state;
    ibuf_state_t              state_n;
    logic [REM_W-1:0]         remaining;
    logic [REM_W-1:0]         remaining_n;
    logic [PORT_W-1:0]        out_port;
    logic [PORT_W-1:0]        out_port_n;
    logic [PORT_W-1:0]        route_table [MAX_NODES];

    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_next;
    logic                     overflow;
    logic                     pop_ok;
    logic                     self_pop;
    logic                     deq;
    logic                     pop_bad;
    logic                     dest_bad;
    logic [DEST_W-1:0]        front_dest;
    logic [LEN_W-1:0]         front_len;
    logic [NUM_OUTPORTS-1:0]  bid_n;
    logic                     route_err_n;

    switch_flit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK          (CLK),
        .RST          (RST),
        .wen          (wen),
        .wdata        (wdata),
        .deq          (deq),
        .rdata_c      (rdata),
        .count        (count),
        .count_next_c (count_next),
        .full         (full),
        .overflow_c   (overflow)
    );

    assign front_dest = rdata[FLIT_W-1 -: DEST_W];
    assign front_len  = rdata[PAYLOAD_W +: LEN_W];

    // Crossbar pops are honoured only while forwarding a non-empty buffer.
    assign pop_ok   = pop && (state == FWD) && (count != '0);
    assign self_pop = (state == DROP) && (count != '0);
    assign deq      = pop_ok || self_pop;
    assign pop_bad  = pop && !pop_ok;

    // Route table: lookups read the pre-edge contents, so same-cycle writes are not seen.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(MAX_NODES); i++) begin
                route_table[i] <= PORT_W'(i % int'(NUM_OUTPORTS));
            end
        end else if (rt_wen && (32'(rt_addr) < TOTAL_NODES)) begin
            route_table[rt_addr] <= rt_port;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ROUTE;
            remaining <= '0;
            out_port  <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            out_port  <= out_port_n;
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        out_port_n  = out_port;
        dest_bad    = 1'b0;
        case (state)
            ROUTE: begin
                if (count != '0) begin
                    remaining_n = REM_W'(front_len) + REM_W'(1);
                    if (32'(front_dest) < TOTAL_NODES) begin
                        out_port_n = route_table[front_dest];
                        state_n    = FWD;
                    end else begin
                        dest_bad = 1'b1;
                        state_n  = DROP;
                    end
                end
            end
            FWD, DROP: begin
                if (deq) begin
                    remaining_n = remaining - REM_W'(1);
                    if (remaining == REM_W'(1)) state_n = ROUTE;
                end
            end
            default: state_n = ROUTE;
        endcase
    end

    // Bid is registered from next-cycle state so it tracks FWD with a non-empty buffer.
    always_comb begin
        bid_n       = '0;
        route_err_n = route_err || dest_bad || pop_bad;
        if ((state_n == FWD) && (count_next != '0)) begin
            bid_n[out_port_n] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bid          <= '0;
            credit_ret   <= 1'b0;
            overflow_err <= 1'b0;
            route_err    <= 1'b0;
        end else begin
            bid          <= bid_n;
            credit_ret   <= deq;
            overflow_err <= overflow_err || overflow;
            route_err    <= route_err_n;
        end
    end

endmodule

// File: tb/tb_switch_input_buffer.sv
// Directed and randomized checks of switch_input_buffer against a packet-level
// queue model of buffer contents, routing and credits.
module tb_switch_input_buffer;
    import switch_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned NOUT  = 4;
    localparam int unsigned NODES = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        wen;
    flit_t       wdata;
    logic        pop;
    logic        rt_wen;
    logic [4:0]  rt_addr;
    logic [1:0]  rt_port;
    logic [3:0]  bid;
    flit_t       rdata;
    logic        full;
    logic        credit_ret;
    logic        overflow_err;
    logic        route_err;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    switch_input_buffer #(
        .DEPTH        (DEPTH),
        .NUM_OUTPORTS (NOUT),
        .TOTAL_NODES  (NODES)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .wen          (wen),
        .wdata        (wdata),
        .pop          (pop),
        .rt_wen       (rt_wen),
        .rt_addr      (rt_addr),
        .rt_port      (rt_port),
        .bid          (bid),
        .rdata        (rdata),
        .full         (full),
        .credit_ret   (credit_ret),
        .overflow_err (overflow_err),
        .route_err    (route_err)
    );

    // Reference model: buffered flits, flits left in the routed packet, its port.
    flit_t mq[$];
    int    m_left;
    bit    m_drop;
    int    m_port;
    int    m_tbl [32];
    bit    m_ovf;
    bit    m_rerr;
    bit    m_credit;

    function automatic flit_t mk_head(input logic [4:0] d, input logic [3:0] l, input logic [22:0] pl);
        head_flit_t h;
        h.dest    = d;
        h.len     = l;
        h.payload = pl;
        return flit_t'(h);
    endfunction

    function automatic logic [3:0] exp_bid();
        if (m_left > 0 && !m_drop && mq.size() > 0) return 4'(1 << m_port);
        return 4'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_left   = 0;
        m_drop   = 1'b0;
        m_port   = 0;
        m_ovf    = 1'b0;
        m_rerr   = 1'b0;
        m_credit = 1'b0;
        for (int i = 0; i < 32; i++) m_tbl[i] = i % int'(NOUT);
    endtask

    task automatic model_step(input logic w, input flit_t d, input logic p,
                              input logic rw, input logic [4:0] ra, input logic [1:0] rp);
        int         n;
        bit         fwd_pop;
        bit         popped;
        head_flit_t h;
        n       = mq.size();
        fwd_pop = (m_left > 0) && !m_drop && (n > 0) && p;
        popped  = fwd_pop || ((m_left > 0) && m_drop && (n > 0));
        if (p && !fwd_pop) m_rerr = 1'b1;
        if (m_left == 0) begin
            if (n > 0) begin
                h      = head_flit_t'(mq[0]);
                m_left = int'(h.len) + 1;
                if (int'(h.dest) < int'(NODES)) begin
                    m_port = m_tbl[h.dest];
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                    m_rerr = 1'b1;
                end
            end
        end else if (popped) begin
            m_left--;
        end
        if (popped) void'(mq.pop_front());
        if (w) begin
            if (n < int'(DEPTH) || popped) mq.push_back(d);
            else m_ovf = 1'b1;
        end
        if (rw && int'(ra) < int'(NODES)) m_tbl[ra] = int'(rp);
        m_credit = popped;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        check("bid", 32'(bid), 32'(exp_bid()));
        check("rdata", rdata, (mq.size() > 0) ? mq[0] : '0);
        check("full", 32'(full), 32'(mq.size() == int'(DEPTH)));
        check("credit_ret", 32'(credit_ret), 32'(m_credit));
        check("overflow_err", 32'(overflow_err), 32'(m_ovf));
        check("route_err", 32'(route_err), 32'(m_rerr));
    endtask

    // One clock cycle: drive, compare current outputs, clock, advance model.
    task automatic cyc(input logic w, input flit_t d, input logic p,
                       input logic rw, input logic [4:0] ra, input logic [1:0] rp);
        wen = w; wdata = d; pop = p; rt_wen = rw; rt_addr = ra; rt_port = rp;
        compare_all();
        @(posedge CLK);
        model_step(w, d, p, rw, ra, rp);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 5'd0, 2'd0);
    endtask

    initial begin
        flit_t      pkt [8];
        flit_t      stream[$];
        flit_t      x9;
        flit_t      nh;
        flit_t      fl;
        logic       w;
        logic       p;
        logic       rw;
        logic [4:0] d5;
        logic [3:0] l4;
        int         sent;
        int         popped;
        int         credits;
        int         bids;

        RST = 1'b1; wen = 1'b0; wdata = '0; pop = 1'b0;
        rt_wen = 1'b0; rt_addr = '0; rt_port = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_bid", 32'(bid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_credit", 32'(credit_ret), 32'h0);
        check("rst_errs", 32'({overflow_err, route_err}), 32'h0);
        RST = 1'b0;

        // Single-flit packet to dest 5 (reset table -> port 1).
        pkt[0] = mk_head(5'd5, 4'd0, 23'h1234);
        cyc(1'b1, pkt[0], 1'b0, 1'b0, 5'd0, 2'd0);
        check("t1_bid_t1", 32'(bid), 32'h0);
        check("t1_front", rdata, pkt[0]);
        idle();
        check("t1_bid_t2", 32'(bid), 32'h2);
        cyc(1'b0, '0, 1'b1, 1'b0, 5'd0, 2'd0);
        check("t1_credit_t3", 32'(credit_ret), 32'h1);
        check("t1_bid_after", 32'(bid), 32'h0);
        idle();
        check("t1_credit_once", 32'(credit_ret), 32'h0);

        // Head len=3 to dest 6 plus 3 bodies, randomly delayed pushes and pops.
        pkt[0] = mk_head(5'd6, 4'd3, 23'($urandom));
        for (int k = 1; k < 4; k++) pkt[k] = flit_t'($urandom);
        sent = 0; popped = 0;
        for (int c = 0; c < 80 && popped < 4; c++) begin
            w = (sent < 4) && ($urandom_range(0, 2) != 0);
            p = (exp_bid() != 4'b0) && ($urandom_range(0, 1) == 1);
            if (p) begin
                check("t2_port", 32'(bid), 32'h4);
                check("t2_order", rdata, pkt[popped]);
                popped++;
            end
            cyc(w, w ? pkt[sent] : '0, p, 1'b0, 5'd0, 2'd0);
            if (w) sent++;
        end
        check("t2_popcount", 32'(popped), 32'd4);
        check("t2_bid_done", 32'(bid), 32'h0);
        idle();

        // Route table write, then lookup; then a write in the lookup cycle itself.
        cyc(1'b0, '0, 1'b0, 1'b1, 5'd7, 2'd3);
        cyc(1'b1, mk_head(5'd7, 4'd0, 23'h7), 1'b0, 1'b0, 5'd0, 2'd0);
        idle();
        check("t3_bid_new", 32'(bid), 32'h8);
        cyc(1'b0, '0, 1'b1, 1'b0, 5'd0, 2'd0);
        cyc(1'b1, mk_head(5'd9, 4'd0, 23'h9), 1'b0, 1'b0, 5'd0, 2'd0);
        cyc(1'b0, '0, 1'b0, 1'b1, 5'd9, 2'd0);
        check("t3_bid_old", 32'(bid), 32'h2);
        cyc(1'b0, '0, 1'b1, 1'b0, 5'd0, 2'd0);
        cyc(1'b1, mk_head(5'd9, 4'd0, 23'h19), 1'b0, 1'b0, 5'd0, 2'd0);
        idle();
        check("t3_bid_updated", 32'(bid), 32'h1);
        cyc(1'b0, '0, 1'b1, 1'b0, 5'd0, 2'd0);
        idle();

        // Unroutable dest 31 (>= 16 nodes): whole packet self-dropped.
        credits = 0; bids = 0;
        for (int k = 0; k < 11; k++) begin
            if (credit_ret === 1'b1) credits++;
            if (bid !== 4'b0) bids++;
            if (k == 0)      cyc(1'b1, mk_head(5'd31, 4'd2, 23'h31), 1'b0, 1'b0, 5'd0, 2'd0);
            else if (k < 3)  cyc(1'b1, flit_t'($urandom), 1'b0, 1'b0, 5'd0, 2'd0);
            else             idle();
        end
        check("t4_route_err", 32'(route_err), 32'h1);
        check("t4_credits", 32'(credits), 32'd3);
        check("t4_no_bid", 32'(bids), 32'd0);
        check("t4_empty", rdata, 32'h0);
        cyc(1'b1, mk_head(5'd2, 4'd0, 23'h2), 1'b0, 1'b0, 5'd0, 2'd0);
        idle();
        check("t4_next_routed", 32'(bid), 32'h4);
        cyc(1'b0, '0, 1'b1, 1'b0, 5'd0, 2'd0);
        idle();

        // Fill to 8, drop a 9th, then pop+push while full.
        pkt[0] = mk_head(5'd1, 4'd7, 23'h11);
        for (int k = 1; k < 8; k++) pkt[k] = flit_t'($urandom);
        for (int k = 0; k < 8; k++) cyc(1'b1, pkt[k], 1'b0, 1'b0, 5'd0, 2'd0);
        check("t5_full", 32'(full), 32'h1);
        check("t5_ovf_pre", 32'(overflow_err), 32'h0);
        x9 = flit_t'($urandom);
        cyc(1'b1, x9, 1'b0, 1'b0, 5'd0, 2'd0);
        check("t5_ovf", 32'(overflow_err), 32'h1);
        check("t5_full_hold", 32'(full), 32'h1);
        nh = mk_head(5'd3, 4'd0, 23'h33);
        cyc(1'b1, nh, 1'b1, 1'b0, 5'd0, 2'd0);
        check("t5_full_after_pp", 32'(full), 32'h1);
        check("t5_credit_pp", 32'(credit_ret), 32'h1);
        for (int k = 1; k < 8; k++) begin
            check("t5_order", rdata, pkt[k]);
            check("t5_bid", 32'(bid), 32'h2);
            cyc(1'b0, '0, 1'b1, 1'b0, 5'd0, 2'd0);
        end
        check("t5_ninth_lost", rdata, nh);
        check("t5_gap", 32'(bid), 32'h0);
        idle();
        check("t5_new_bid", 32'(bid), 32'h8);
        cyc(1'b0, '0, 1'b1, 1'b0, 5'd0, 2'd0);
        idle();

        // Random packets, pops and table writes.
        for (int c = 0; c < 300; c++) begin
            if (stream.size() == 0) begin
                d5 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
                l4 = 4'($urandom_range(0, 4));
                stream.push_back(mk_head(d5, l4, 23'($urandom)));
                for (int k = 0; k < int'(l4); k++) stream.push_back(flit_t'($urandom));
            end
            p  = (exp_bid() != 4'b0) && ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 1) == 1) && ((mq.size() < int'(DEPTH)) || p);
            rw = ($urandom_range(0, 15) == 0);
            cyc(w, stream[0], p, rw, 5'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            if (w) void'(stream.pop_front());
        end
        for (int c = 0; c < 300 && (stream.size() > 0 || mq.size() > 0 || m_left > 0); c++) begin
            p  = (exp_bid() != 4'b0);
            w  = (stream.size() > 0) && ((mq.size() < int'(DEPTH)) || p);
            fl = (stream.size() > 0) ? stream[0] : '0;
            cyc(w, fl, p, 1'b0, 5'd0, 2'd0);
            if (w) void'(stream.pop_front());
        end
        check("drain_rdata", rdata, 32'h0);
        check("drain_bid", 32'(bid), 32'h0);

        // Reset mid-packet with 5 flits stored; errors are sticky-high beforehand.
        cyc(1'b1, mk_head(5'd4, 4'd10, 23'h44), 1'b0, 1'b0, 5'd0, 2'd0);
        for (int k = 0; k < 4; k++) cyc(1'b1, flit_t'($urandom), 1'b0, 1'b0, 5'd0, 2'd0);
        check("t7_pre_rdata_nz", 32'(rdata != '0), 32'h1);
        check("t7_pre_ovf", 32'(overflow_err), 32'h1);
        wen = 1'b0; pop = 1'b0; rt_wen = 1'b0;
        #1 RST = 1'b1;
        #1;
        check("t7_rst_bid", 32'(bid), 32'h0);
        check("t7_rst_rdata", rdata, 32'h0);
        check("t7_rst_full", 32'(full), 32'h0);
        check("t7_rst_credit", 32'(credit_ret), 32'h0);
        check("t7_rst_ovf", 32'(overflow_err), 32'h0);
        check("t7_rst_rerr", 32'(route_err), 32'h0);
        model_reset();
        @(posedge CLK);
        #1 RST = 1'b0;
        cyc(1'b1, mk_head(5'd5, 4'd0, 23'h55), 1'b0, 1'b0, 5'd0, 2'd0);
        check("t7_post_bid_t1", 32'(bid), 32'h0);
        idle();
        check("t7_post_bid_t2", 32'(bid), 32'h2);
        cyc(1'b0, '0, 1'b1, 1'b0, 5'd0, 2'd0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
